// File: rtl/chick_pkg.sv
// Shared constants, state encoding and track arithmetic
// for the chicken race turn controller.
package chick_pkg;

    localparam int TRACK_LEN   = 24;
    localparam int PIC_W       = 4;
    localparam int MAX_PLAYERS = 4;
    localparam int PLR_W       = 2;
    localparam int POS_W       = 5;

    typedef enum logic [1:0] {
        WAIT_CARD = 2'd0,
        SEEK      = 2'd1,
        MOVE      = 2'd2,
        NEXT      = 2'd3
    } state_e;

    function automatic logic [POS_W-1:0] wrap_pos(input logic [5:0] s);
        logic [5:0] r;
        r = s;
        if (s >= 6'(TRACK_LEN))
            r = s - 6'(TRACK_LEN);
        return r[POS_W-1:0];
    endfunction

endpackage

// File: rtl/chick_turn_ctrl_if.sv
// Card input, counter feedback and advance-enable bundle
// between the game board and the turn controller.
interface chick_turn_ctrl_if;
    import chick_pkg::*;

    logic [3:0]       N;
    logic             card_valid;
    logic [PIC_W-1:0] card_pic;
    logic [4:0]       p1_cnt;
    logic [4:0]       p2_cnt;
    logic [4:0]       p3_cnt;
    logic [4:0]       p4_cnt;
    logic             p_da1;
    logic             p_da2;
    logic             p_da3;
    logic             p_da4;
    logic [1:0]       cur_player;
    logic             busy;
    logic             hit;
    logic             miss;

    modport master (
        output N, card_valid, card_pic,
        output p1_cnt, p2_cnt, p3_cnt, p4_cnt,
        input  p_da1, p_da2, p_da3, p_da4,
        input  cur_player, busy, hit, miss
    );

    modport slave (
        input  N, card_valid, card_pic,
        input  p1_cnt, p2_cnt, p3_cnt, p4_cnt,
        output p_da1, p_da2, p_da3, p_da4,
        output cur_player, busy, hit, miss
    );

endinterface

// File: rtl/track_pic_rom.sv
// Tile picture lookup: pic(i) = i mod 12 on the track,
// off-track indices return all-ones which no card carries.
module track_pic_rom
    import chick_pkg::*;
(
    input  logic [POS_W-1:0] idx_i,
    output logic [PIC_W-1:0] pic_o
);

    always_comb begin
        pic_o = '1;
        if (idx_i < 5'(TRACK_LEN)) begin
            if (idx_i >= 5'd12)
                pic_o = PIC_W'(idx_i - 5'd12);
            else
                pic_o = PIC_W'(idx_i);
        end
    end

endmodule

// File: rtl/chick_turn_ctrl.sv
// Turn/move controller: seeks the current player's target tile,
// then drives that player's advance enable for the hop distance.
module chick_turn_ctrl
    import chick_pkg::*;
(
    input logic              B,
    input logic              rst,
    chick_turn_ctrl_if.slave bus
);

    state_e             state_q, state_d;
    logic [PLR_W-1:0]   cur_q, cur_d;
    logic [2:0]         off_q, off_d;
    logic [2:0]         dist_q, dist_d;
    logic [PIC_W-1:0]   card_q, card_d;
    logic [3:0]         pda_q, pda_d;

    logic [POS_W-1:0]   pos [MAX_PLAYERS];
    logic [2:0]         neff;
    logic [POS_W-1:0]   probe;
    logic [PIC_W-1:0]   probe_pic;
    logic               occ;
    logic               hit_c, miss_c;

    assign pos[0] = bus.p1_cnt;
    assign pos[1] = bus.p2_cnt;
    assign pos[2] = bus.p3_cnt;
    assign pos[3] = bus.p4_cnt;

    assign neff  = (bus.N >= 4'd2 && bus.N <= 4'd4) ? bus.N[2:0] : 3'd2;
    assign probe = wrap_pos({1'b0, pos[cur_q]} + {3'b0, off_q});

    track_pic_rom u_rom (
        .idx_i (probe),
        .pic_o (probe_pic)
    );

    // Only other active players block a tile.
    always_comb begin
        occ = 1'b0;
        for (int j = 0; j < MAX_PLAYERS; j++) begin
            if (j != int'(cur_q) && j < int'(neff) && pos[j] == probe)
                occ = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        off_d   = off_q;
        dist_d  = dist_q;
        card_d  = card_q;
        pda_d   = pda_q;
        hit_c   = 1'b0;
        miss_c  = 1'b0;
        unique case (state_q)
            WAIT_CARD: begin
                if (bus.card_valid) begin
                    card_d  = bus.card_pic;
                    off_d   = 3'd1;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (occ) begin
                    off_d = off_q + 3'd1;
                end else if (probe_pic == card_q) begin
                    hit_c   = 1'b1;
                    dist_d  = off_q;
                    pda_d   = 4'b0001 << cur_q;
                    state_d = MOVE;
                end else begin
                    miss_c  = 1'b1;
                    state_d = NEXT;
                end
            end
            MOVE: begin
                if (dist_q <= 3'd1) begin
                    dist_d  = 3'd0;
                    pda_d   = 4'b0000;
                    state_d = WAIT_CARD;
                end else begin
                    dist_d = dist_q - 3'd1;
                end
            end
            NEXT: begin
                if ({1'b0, cur_q} >= neff - 3'd1)
                    cur_d = '0;
                else
                    cur_d = cur_q + 2'd1;
                state_d = WAIT_CARD;
            end
            default: state_d = WAIT_CARD;
        endcase
    end

    always_ff @(posedge B or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_CARD;
            cur_q   <= '0;
            off_q   <= '0;
            dist_q  <= '0;
            card_q  <= '0;
            pda_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            off_q   <= off_d;
            dist_q  <= dist_d;
            card_q  <= card_d;
            pda_q   <= pda_d;
        end
    end

    assign bus.p_da1      = pda_q[0];
    assign bus.p_da2      = pda_q[1];
    assign bus.p_da3      = pda_q[2];
    assign bus.p_da4      = pda_q[3];
    assign bus.cur_player = cur_q;
    assign bus.busy       = (state_q != WAIT_CARD);
    assign bus.hit        = hit_c;
    assign bus.miss       = miss_c;

endmodule
